// File: rtl/lisa_uart_rx_pkg.sv
// Shared types and constants for the Lisa UART receiver: parity modes, FSM states
// and the oversampling geometry.
package lisa_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic parity_enabled(input parity_mode_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/lisa_uart_rx_if.sv
// Peripheral read port of the UART receiver: the core pops characters and reads
// the head entry, its error flags, the FIFO level and the sticky overrun flag.
interface lisa_uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd;
  logic             clr_ovr;
  logic [7:0]       d;
  logic             parity_err;
  logic             frame_err;
  logic             data_avail;
  logic [LVL_W-1:0] fifo_level;
  logic             overrun;

  modport master (
    output rd, clr_ovr,
    input  d, parity_err, frame_err, data_avail, fifo_level, overrun
  );

  modport slave (
    input  rd, clr_ovr,
    output d, parity_err, frame_err, data_avail, fifo_level, overrun
  );

endinterface

// File: rtl/lisa_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is readable combinationally and a
// push is still accepted when full if a pop happens in the same cycle.
module lisa_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lisa_uart_rx.sv
// 16x-oversampling UART receiver with 5..8 data bits, optional parity, start-bit
// glitch rejection and a show-ahead receive FIFO carrying per-character errors.
module lisa_uart_rx
  import lisa_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         baud_ref,
  input  logic         rxd,
  input  logic [1:0]   parity_mode,
  lisa_uart_rx_if.slave bus
);

  localparam int          FW       = DATA_BITS + 2;
  localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  MID_CNT  = 4'(MID_SAMPLE);
  localparam logic [3:0]  LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  // Even parity: data plus parity bit XOR to 0; odd: to 1.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic pbit, input parity_mode_e mode);
    return (^data ^ pbit) != (mode == PAR_ODD);
  endfunction

  logic                 rxd_p0, rxd_p1;
  logic                 baud_ref_q, rd_q;
  logic                 tick;

  rx_state_e            state, state_nxt;
  logic [3:0]           os_cnt, os_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  parity_mode_e         pmode_q, pmode_nxt;
  logic                 perr_q, perr_nxt;
  logic                 push, ferr_push;

  logic [FW-1:0]        head;
  logic                 fifo_empty, fifo_full, pop;
  logic [LVL_W-1:0]     level;
  logic                 overrun_q;

  // Input stage: rxd synchroniser and edge detectors for baud_ref and rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0     <= 1'b1;
      rxd_p1     <= 1'b1;
      baud_ref_q <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      rxd_p0     <= rxd;
      rxd_p1     <= rxd_p0;
      baud_ref_q <= baud_ref;
      rd_q       <= bus.rd;
    end
  end

  assign tick = baud_ref & ~baud_ref_q;
  assign pop  = bus.rd & ~rd_q & ~fifo_empty;

  // Receiver FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      pmode_q <= PAR_NONE;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_cnt <= bit_nxt;
      pmode_q <= pmode_nxt;
      perr_q  <= perr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_nxt;
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    pmode_nxt = pmode_q;
    perr_nxt  = perr_q;
    push      = 1'b0;
    ferr_push = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rxd_p1) begin
            state_nxt = ST_START;
            os_nxt    = '0;
            bit_nxt   = '0;
            perr_nxt  = 1'b0;
            pmode_nxt = parity_mode_e'(parity_mode);
          end
        end
        ST_START: begin
          if (os_cnt == MID_CNT && rxd_p1) begin
            state_nxt = ST_IDLE;
            os_nxt    = '0;
          end else begin
            os_nxt = os_cnt + 4'd1;
            if (os_cnt == LAST_CNT) state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          os_nxt = os_cnt + 4'd1;
          if (os_cnt == MID_CNT) shift_nxt = {rxd_p1, shift_q[DATA_BITS-1:1]};
          if (os_cnt == LAST_CNT) begin
            if (bit_cnt == BIT_LAST)
              state_nxt = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
            else
              bit_nxt = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          os_nxt = os_cnt + 4'd1;
          if (os_cnt == MID_CNT) perr_nxt = parity_bad(shift_q, rxd_p1, pmode_q);
          if (os_cnt == LAST_CNT) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (os_cnt == MID_CNT) begin
            push      = 1'b1;
            ferr_push = ~rxd_p1;
            state_nxt = ST_IDLE;
            os_nxt    = '0;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Receive FIFO stage.
  lisa_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({shift_q, perr_q, ferr_push}),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  // A dropped character sets overrun; a simultaneous clear loses.
  always_ff @(posedge clk) begin
    if (rst)                            overrun_q <= 1'b0;
    else if (push & fifo_full & ~pop)   overrun_q <= 1'b1;
    else if (bus.clr_ovr)               overrun_q <= 1'b0;
  end

  assign bus.d          = fifo_empty ? 8'h00 : 8'(head[FW-1:2]);
  assign bus.parity_err = ~fifo_empty & head[1];
  assign bus.frame_err  = ~fifo_empty & head[0];
  assign bus.data_avail = ~fifo_empty;
  assign bus.fifo_level = level;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_lisa_uart_rx.sv
// Directed bench for lisa_uart_rx: an 8-bit and a 7-bit receiver driven by frames
// built cycle by cycle, with expected values written out by hand in each test.
module tb_lisa_uart_rx;

  logic       clk, rst, baud_ref, rxd8, rxd7;
  logic [1:0] parity_mode;
  int         checks, errors, push_cyc;

  lisa_uart_rx_if #(.FIFO_DEPTH(4)) bus8 ();
  lisa_uart_rx_if #(.FIFO_DEPTH(4)) bus7 ();

  lisa_uart_rx #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .baud_ref(baud_ref), .rxd(rxd8),
    .parity_mode(parity_mode), .bus(bus8.slave));

  lisa_uart_rx #(.DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst), .baud_ref(baud_ref), .rxd(rxd7),
    .parity_mode(parity_mode), .bus(bus7.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One baud_ref rising edge every 4 clocks, high for one clock.
  initial begin
    baud_ref = 1'b0;
    #1;
    forever begin
      baud_ref = 1'b1; #10;
      baud_ref = 1'b0; #30;
    end
  end

  // 64 clocks per bit; stop bit holds stop_bit for 40 clocks then idles high.
  task automatic send_frame(input bit sel7, input logic [7:0] data, input int nbits,
                            input bit par_en, input bit par_bit, input bit stop_bit,
                            input int rd_at, input int rst_at);
    int nb_total, ncyc, bi, off;
    logic v;
    bit aborted;
    logic [2:0] lvl0;
    nb_total = nbits + (par_en ? 1 : 0) + 2;
    ncyc     = nb_total * 64 + 32;
    aborted  = 1'b0;
    push_cyc = -1;
    do @(negedge clk); while (baud_ref !== 1'b1);
    lvl0 = bus8.fifo_level;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (push_cyc < 0 && bus8.fifo_level != lvl0) push_cyc = i;
      bi  = i / 64;
      off = i % 64;
      if (bi == 0)                         v = 1'b0;
      else if (bi <= nbits)                v = data[bi-1];
      else if (par_en && bi == nbits + 1)  v = par_bit;
      else if (bi == nb_total - 1 && off < 40) v = stop_bit;
      else                                 v = 1'b1;
      if (i == rst_at) begin rst = 1'b1; aborted = 1'b1; end
      if (i == rst_at + 2) rst = 1'b0;
      if (aborted) v = 1'b1;
      if (sel7) rxd7 = v; else rxd8 = v;
      if (i == rd_at)     bus8.rd = 1'b1;
      if (i == rd_at + 1) bus8.rd = 1'b0;
    end
  endtask

  task automatic pop8();
    @(negedge clk) bus8.rd = 1'b1;
    @(negedge clk) bus8.rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus8.d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h want 00", bus8.d); end
    checks++; if (bus8.data_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b want 0", bus8.data_avail); end
    checks++; if (bus8.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus8.fifo_level); end
    checks++; if (bus8.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus8.overrun); end
    checks++; if ({bus8.parity_err, bus8.frame_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {bus8.parity_err, bus8.frame_err}); end
  endtask

  task automatic test_8n1();
    parity_mode = 2'b00;
    send_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if (bus8.d !== 8'hA5) begin errors++; $display("FAIL 8n1_d: got %h want a5", bus8.d); end
    checks++; if (bus8.data_avail !== 1'b1) begin errors++; $display("FAIL 8n1_avail: got %b want 1", bus8.data_avail); end
    checks++; if ({bus8.parity_err, bus8.frame_err} !== 2'b00) begin errors++; $display("FAIL 8n1_errs: got %b want 00", {bus8.parity_err, bus8.frame_err}); end
    checks++; if (bus8.fifo_level !== 3'd1) begin errors++; $display("FAIL 8n1_level: got %0d want 1", bus8.fifo_level); end
    pop8();
    checks++; if (bus8.fifo_level !== 3'd0) begin errors++; $display("FAIL 8n1_pop_level: got %0d want 0", bus8.fifo_level); end
    checks++; if (bus8.d !== 8'h00) begin errors++; $display("FAIL 8n1_pop_d: got %h want 00", bus8.d); end
  endtask

  task automatic test_parity();
    parity_mode = 2'b01;
    send_frame(1'b0, 8'h03, 8, 1'b1, 1'b1, 1'b1, -1, -1);
    checks++; if (bus8.parity_err !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b want 1", bus8.parity_err); end
    checks++; if (bus8.d !== 8'h03) begin errors++; $display("FAIL even_bad_d: got %h want 03", bus8.d); end
    pop8();
    send_frame(1'b0, 8'h03, 8, 1'b1, 1'b0, 1'b1, -1, -1);
    checks++; if (bus8.parity_err !== 1'b0) begin errors++; $display("FAIL even_ok_perr: got %b want 0", bus8.parity_err); end
    checks++; if (bus8.d !== 8'h03) begin errors++; $display("FAIL even_ok_d: got %h want 03", bus8.d); end
    pop8();
    parity_mode = 2'b10;
    send_frame(1'b0, 8'h03, 8, 1'b1, 1'b1, 1'b1, -1, -1);
    checks++; if (bus8.parity_err !== 1'b0) begin errors++; $display("FAIL odd_ok_perr: got %b want 0", bus8.parity_err); end
    pop8();
    parity_mode = 2'b00;
  endtask

  task automatic test_frame_err();
    send_frame(1'b0, 8'h55, 8, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++; if (bus8.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", bus8.frame_err); end
    checks++; if (bus8.d !== 8'h55) begin errors++; $display("FAIL ferr_d: got %h want 55", bus8.d); end
    pop8();
    send_frame(1'b0, 8'h12, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if ({bus8.d, bus8.parity_err, bus8.frame_err} !== {8'h12, 2'b00}) begin errors++; $display("FAIL ferr_next: got %h/%b%b want 12/00", bus8.d, bus8.parity_err, bus8.frame_err); end
    checks++; if (bus8.fifo_level !== 3'd1) begin errors++; $display("FAIL ferr_next_level: got %0d want 1", bus8.fifo_level); end
    pop8();
  endtask

  task automatic test_glitch();
    @(negedge clk) rxd8 = 1'b0;
    repeat (16) @(negedge clk);
    rxd8 = 1'b1;
    repeat (120) @(negedge clk);
    checks++; if (bus8.fifo_level !== 3'd0) begin errors++; $display("FAIL glitch_level: got %0d want 0", bus8.fifo_level); end
    send_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if (bus8.d !== 8'h3C) begin errors++; $display("FAIL glitch_after_d: got %h want 3c", bus8.d); end
    pop8();
  endtask

  task automatic test_overrun();
    int meas;
    meas = -1;
    for (int k = 1; k <= 5; k++) begin
      send_frame(1'b0, 8'(k), 8, 1'b0, 1'b0, 1'b1, -1, -1);
      if (k == 1) meas = push_cyc;
    end
    checks++; if (meas < 0) begin errors++; $display("FAIL ovr_push_seen: got %0d want >=0", meas); end
    checks++; if (bus8.fifo_level !== 3'd4) begin errors++; $display("FAIL ovr_level: got %0d want 4", bus8.fifo_level); end
    checks++; if (bus8.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", bus8.overrun); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus8.d !== 8'(k)) begin errors++; $display("FAIL ovr_pop_d: got %h want %h", bus8.d, 8'(k)); end
      pop8();
    end
    checks++; if (bus8.data_avail !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b want 0", bus8.data_avail); end
    @(negedge clk) bus8.clr_ovr = 1'b1;
    @(negedge clk) bus8.clr_ovr = 1'b0;
    checks++; if (bus8.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus8.overrun); end
    for (int k = 6; k <= 9; k++) send_frame(1'b0, 8'(k), 8, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(1'b0, 8'h0A, 8, 1'b0, 1'b0, 1'b1, meas - 1, -1);
    checks++; if (bus8.overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovr: got %b want 0", bus8.overrun); end
    checks++; if (bus8.fifo_level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level: got %0d want 4", bus8.fifo_level); end
    for (int k = 7; k <= 10; k++) begin
      checks++; if (bus8.d !== 8'(k)) begin errors++; $display("FAIL full_pushpop_d: got %h want %h", bus8.d, 8'(k)); end
      pop8();
    end
  endtask

  task automatic test_7bit_reset();
    send_frame(1'b1, 8'h7F, 7, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if (bus7.d !== 8'h7F) begin errors++; $display("FAIL b7_d: got %h want 7f", bus7.d); end
    checks++; if (bus7.d[7] !== 1'b0) begin errors++; $display("FAIL b7_msb: got %b want 0", bus7.d[7]); end
    checks++; if (bus7.fifo_level !== 3'd1) begin errors++; $display("FAIL b7_level: got %0d want 1", bus7.fifo_level); end
    send_frame(1'b1, 8'h2A, 7, 1'b0, 1'b0, 1'b1, -1, 200);
    checks++; if ({bus7.d, bus7.parity_err, bus7.frame_err, bus7.data_avail, bus7.overrun} !== 12'h000) begin errors++; $display("FAIL b7_rst_outs: got %h/%b%b%b%b want 00/0000", bus7.d, bus7.parity_err, bus7.frame_err, bus7.data_avail, bus7.overrun); end
    checks++; if (bus7.fifo_level !== 3'd0) begin errors++; $display("FAIL b7_rst_level: got %0d want 0", bus7.fifo_level); end
    send_frame(1'b1, 8'h15, 7, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++; if ({bus7.d, bus7.frame_err} !== {8'h15, 1'b0}) begin errors++; $display("FAIL b7_after_rst: got %h/%b want 15/0", bus7.d, bus7.frame_err); end
    checks++; if (bus7.fifo_level !== 3'd1) begin errors++; $display("FAIL b7_after_level: got %0d want 1", bus7.fifo_level); end
  endtask

  initial begin
    checks = 0; errors = 0; push_cyc = -1;
    rst = 1'b1; rxd8 = 1'b1; rxd7 = 1'b1; parity_mode = 2'b00;
    bus8.rd = 1'b0; bus8.clr_ovr = 1'b0;
    bus7.rd = 1'b0; bus7.clr_ovr = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_7bit_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
